// File: rtl/simplerisc_pkg.sv
// Shared SimpleRISC definitions: opcodes, instruction field positions and the
// decoded-field bundle carried from decode into the ID/EX register.
package simplerisc_pkg;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_MUL  = 5'd2;
    localparam logic [4:0] OP_DIV  = 5'd3;
    localparam logic [4:0] OP_MOD  = 5'd4;
    localparam logic [4:0] OP_CMP  = 5'd5;
    localparam logic [4:0] OP_AND  = 5'd6;
    localparam logic [4:0] OP_OR   = 5'd7;
    localparam logic [4:0] OP_NOT  = 5'd8;
    localparam logic [4:0] OP_MOV  = 5'd9;
    localparam logic [4:0] OP_LSL  = 5'd10;
    localparam logic [4:0] OP_LSR  = 5'd11;
    localparam logic [4:0] OP_ASR  = 5'd12;
    localparam logic [4:0] OP_NOP  = 5'd13;
    localparam logic [4:0] OP_LD   = 5'd14;
    localparam logic [4:0] OP_ST   = 5'd15;
    localparam logic [4:0] OP_BEQ  = 5'd16;
    localparam logic [4:0] OP_BGT  = 5'd17;
    localparam logic [4:0] OP_B    = 5'd18;
    localparam logic [4:0] OP_CALL = 5'd19;
    localparam logic [4:0] OP_RET  = 5'd20;

    localparam int OPC_HI = 31, OPC_LO = 27, IMM_BIT = 26;
    localparam int RD_HI  = 25, RD_LO  = 22;
    localparam int RS1_HI = 21, RS1_LO = 18;
    localparam int RS2_HI = 17, RS2_LO = 14;

    localparam logic [3:0] RA_DEFAULT = 4'd15;

    typedef struct packed {
        logic [4:0] op;
        logic       imm;
        logic [3:0] rs1;
        logic [3:0] rs2;
        logic [3:0] rd;
        logic       rs1_en;
        logic       rs2_en;
        logic       rd_we;
        logic       illegal;
    } dec_t;

endpackage

// File: rtl/instr_class_decode.sv
// Pure combinational SimpleRISC decode: instruction word to register indices
// and enables. Indices are forced to 0 whenever their enable is low.
module instr_class_decode
    import simplerisc_pkg::*;
#(
    parameter logic [3:0] RA = RA_DEFAULT
) (
    input  logic [31:0] instr,
    output dec_t        dec
);

    logic [4:0] op;
    logic       imm;
    logic [3:0] rs1, rs2, rd;
    logic       rs1_en, rs2_en, rd_we, illegal;

    always_comb begin
        op      = instr[OPC_HI:OPC_LO];
        imm     = instr[IMM_BIT];
        rs1     = instr[RS1_HI:RS1_LO];
        rs2     = instr[RS2_HI:RS2_LO];
        rd      = instr[RD_HI:RD_LO];
        rs1_en  = 1'b0;
        rs2_en  = 1'b0;
        rd_we   = 1'b0;
        illegal = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD, OP_AND, OP_OR,
            OP_LSL, OP_LSR, OP_ASR: begin
                rs1_en = 1'b1;
                rs2_en = !imm;
                rd_we  = 1'b1;
            end
            OP_CMP: begin
                rs1_en = 1'b1;
                rs2_en = !imm;
            end
            OP_NOT, OP_MOV: begin
                rs2_en = !imm;
                rd_we  = 1'b1;
            end
            OP_LD: begin
                rs1_en = 1'b1;
                rd_we  = 1'b1;
            end
            // store data register lives in the rd field
            OP_ST: begin
                rs1_en = 1'b1;
                rs2_en = 1'b1;
                rs2    = instr[RD_HI:RD_LO];
            end
            OP_CALL: begin
                rd_we = 1'b1;
                rd    = RA;
            end
            OP_RET: begin
                rs1_en = 1'b1;
                rs1    = RA;
            end
            OP_NOP, OP_BEQ, OP_BGT, OP_B: begin
            end
            default: illegal = 1'b1;
        endcase

        dec.op      = op;
        dec.imm     = imm;
        dec.rs1     = rs1_en ? rs1 : 4'd0;
        dec.rs2     = rs2_en ? rs2 : 4'd0;
        dec.rd      = rd_we ? rd : 4'd0;
        dec.rs1_en  = rs1_en;
        dec.rs2_en  = rs2_en;
        dec.rd_we   = rd_we;
        dec.illegal = illegal;
    end

endmodule

// File: rtl/id_stage_scoreboard.sv
// Registered SimpleRISC ID stage with a per-register pending-write scoreboard.
// Define DEC_WB_BYPASS_EN to let a same-cycle writeback clear a RAW hazard.
module id_stage_scoreboard
    import simplerisc_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int RA_IDX   = 15,
    parameter int SB_CNT_W = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_op,
    output logic        out_imm,
    output logic [3:0]  out_rs1,
    output logic [3:0]  out_rs2,
    output logic [3:0]  out_rd,
    output logic        out_rs1_en,
    output logic        out_rs2_en,
    output logic        out_rd_we,
    output logic        out_illegal,
    input  logic        wb_valid,
    input  logic [3:0]  wb_reg,
    output logic        stall,
    output logic        sb_err
);

    localparam int                  CW      = SB_CNT_W + 2;
    localparam logic [SB_CNT_W-1:0] CNT_MAX = '1;

    dec_t                d, q;
    logic [SB_CNT_W-1:0] cnt    [NUM_REGS];
    logic [SB_CNT_W-1:0] cnt_nx [NUM_REGS];
    logic [CW-1:0]       up, dn;
    logic                hazard, capture, wb_zero;

    instr_class_decode #(.RA(4'(RA_IDX))) u_dec (
        .instr (in_instr),
        .dec   (d)
    );

    // Count seen by the hazard check; indices beyond NUM_REGS read as idle.
    function automatic logic [SB_CNT_W-1:0] pend(input logic [3:0] idx);
        logic [SB_CNT_W-1:0] c;
        c = '0;
        for (int r = 0; r < NUM_REGS; r++)
            if (idx == 4'(r)) c = cnt[r];
`ifdef DEC_WB_BYPASS_EN
        if (wb_valid && wb_reg == idx && c != '0) c = c - SB_CNT_W'(1);
`endif
        return c;
    endfunction

    always_comb begin
        hazard = in_valid && ((d.rs1_en && pend(d.rs1) != '0) ||
                              (d.rs2_en && pend(d.rs2) != '0) ||
                              (d.rd_we  && pend(d.rd)  == CNT_MAX));
    end

    assign stall    = hazard;
    assign in_ready = !hazard && !flush && (!out_valid || out_ready);
    assign capture  = in_valid && in_ready;

    // Issue, writeback and flush-drop combine as a net sum, floored at 0.
    always_comb begin
        up      = '0;
        dn      = '0;
        wb_zero = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            up = CW'(cnt[r]) + CW'(capture && d.rd_we && d.rd == 4'(r));
            dn = CW'(wb_valid && wb_reg == 4'(r)) +
                 CW'(flush && out_valid && q.rd_we && q.rd == 4'(r));
            cnt_nx[r] = (up > dn) ? SB_CNT_W'(up - dn) : '0;
            if (wb_valid && wb_reg == 4'(r) && cnt[r] == '0) wb_zero = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
            sb_err <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) cnt[r] <= cnt_nx[r];
            if (wb_zero) sb_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            q         <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (capture) begin
            out_valid <= 1'b1;
            q         <= d;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign out_op      = q.op;
    assign out_imm     = q.imm;
    assign out_rs1     = q.rs1;
    assign out_rs2     = q.rs2;
    assign out_rd      = q.rd;
    assign out_rs1_en  = q.rs1_en;
    assign out_rs2_en  = q.rs2_en;
    assign out_rd_we   = q.rd_we;
    assign out_illegal = q.illegal;

endmodule

// File: tb/tb_id_stage_scoreboard.sv
// Self-checking bench for id_stage_scoreboard: directed scenarios followed by
// randomized traffic, all compared against a behavioural reference model.
module tb_id_stage_scoreboard;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] in_instr;
    logic [4:0]  out_op;
    logic        out_imm, out_rs1_en, out_rs2_en, out_rd_we, out_illegal;
    logic [3:0]  out_rs1, out_rs2, out_rd, wb_reg;
    logic        wb_valid, stall, sb_err;

    int checks   = 0;
    int failures = 0;

    localparam int MAXC = 3;

    int          mcnt [16];
    bit          merr, m_ov, known;
    logic [21:0] mout;
    logic        last_stall;

    always #5 clk = ~clk;

    id_stage_scoreboard dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_op(out_op), .out_imm(out_imm),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_rs1_en(out_rs1_en), .out_rs2_en(out_rs2_en),
        .out_rd_we(out_rd_we), .out_illegal(out_illegal),
        .wb_valid(wb_valid), .wb_reg(wb_reg), .stall(stall), .sb_err(sb_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Layout: op[21:17] imm[16] rs1[15:12] rs2[11:8] rd[7:4] rs1_en rs2_en rd_we illegal
    function automatic logic [21:0] ref_decode(input logic [31:0] w);
        int op, rd, a, b, r1, r2, rdst;
        bit i, e1, e2, we, ill;
        op = int'(w[31:27]); i = w[26];
        rd = int'(w[25:22]); a = int'(w[21:18]); b = int'(w[17:14]);
        e1  = op inside {[0:7], [10:12], 14, 15, 20};
        e2  = (op <= 12 && !i) || op == 15;
        we  = op inside {[0:4], [6:12], 14, 19};
        ill = op > 20;
        r1   = !e1 ? 0 : (op == 20 ? 15 : a);
        r2   = !e2 ? 0 : (op == 15 ? rd : b);
        rdst = !we ? 0 : (op == 19 ? 15 : rd);
        return {5'(op), i, 4'(r1), 4'(r2), 4'(rdst), e1, e2, we, ill};
    endfunction

    function automatic int pend(input int r);
        int c = mcnt[r];
`ifdef DEC_WB_BYPASS_EN
        if (wb_valid && int'(wb_reg) == r && c > 0) c--;
`endif
        return c;
    endfunction

    // One clock: check mid-cycle against the model, then advance the model.
    task automatic step();
        logic [21:0] d;
        bit haz, rdy, cap, nerr;
        int delta [16];
        @(negedge clk);
        d   = ref_decode(in_instr);
        haz = in_valid && ((d[3] && pend(int'(d[15:12])) > 0) ||
                           (d[2] && pend(int'(d[11:8])) > 0) ||
                           (d[1] && pend(int'(d[7:4])) == MAXC));
        rdy = !haz && !flush && (!m_ov || out_ready);
        last_stall = stall;
        if (known) begin
            chk("stall", 32'(stall), 32'(haz));
            chk("in_ready", 32'(in_ready), 32'(rdy));
            chk("out_valid", 32'(out_valid), 32'(m_ov));
            chk("sb_err", 32'(sb_err), 32'(merr));
            if (m_ov)
                chk("out_fields", 32'({out_op, out_imm, out_rs1, out_rs2, out_rd,
                    out_rs1_en, out_rs2_en, out_rd_we, out_illegal}), 32'(mout));
        end
        cap  = in_valid && rdy;
        nerr = 1'b0;
        for (int r = 0; r < 16; r++) delta[r] = 0;
        if (cap && d[1]) delta[d[7:4]]++;
        if (wb_valid) begin
            if (mcnt[wb_reg] == 0) nerr = 1'b1;
            delta[wb_reg]--;
        end
        if (flush && m_ov && mout[1]) delta[mout[7:4]]--;
        @(posedge clk);
        #1;
        if (rst) begin
            for (int r = 0; r < 16; r++) mcnt[r] = 0;
            merr = 1'b0; m_ov = 1'b0; mout = '0; known = 1'b1;
        end else begin
            for (int r = 0; r < 16; r++) begin
                mcnt[r] += delta[r];
                if (mcnt[r] < 0) mcnt[r] = 0;
            end
            if (nerr) merr = 1'b1;
            if (flush) m_ov = 1'b0;
            else if (cap) begin m_ov = 1'b1; mout = d; end
            else if (out_ready) m_ov = 1'b0;
        end
    endtask

    initial begin
        known = 1'b0; m_ov = 1'b0; merr = 1'b0; mout = '0;
        rst = 1; in_valid = 0; in_instr = '0; flush = 0; out_ready = 1;
        wb_valid = 0; wb_reg = '0;
        step();
        rst = 0;
        step();
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_sb_err", 32'(sb_err), 0);
        chk("rst_fields", 32'({out_op, out_imm, out_rs1, out_rs2, out_rd,
            out_rs1_en, out_rs2_en, out_rd_we, out_illegal}), 0);

        // RAW: add r1 then reader of r1
        in_valid = 1; in_instr = 32'h0048C000; step();
        chk("add_valid", 32'(out_valid), 1);
        chk("add_rd", 32'(out_rd), 1);
        in_instr = 32'h0904C000; step();
        chk("raw_stall", 32'(last_stall), 1);
        wb_valid = 1; wb_reg = 4'd1; step(); wb_valid = 0;
`ifdef DEC_WB_BYPASS_EN
        chk("raw_bypass_issue", 32'(last_stall), 0);
`else
        chk("raw_wb_cycle_stall", 32'(last_stall), 1);
        step();
        chk("raw_release", 32'(last_stall), 0);
`endif
        chk("sub_valid", 32'(out_valid), 1);
        chk("sub_rs1", 32'(out_rs1), 1);
        in_valid = 0; step();

        // Flush drops the pending write of the held add r1
        out_ready = 0; in_valid = 1; in_instr = 32'h0048C000; step();
        in_valid = 0; flush = 1; step(); flush = 0;
        chk("flush_valid", 32'(out_valid), 0);
        in_valid = 1; in_instr = 32'h0904C000; step();
        chk("flush_reader_issue", 32'(last_stall), 0);
        chk("flush_reader_valid", 32'(out_valid), 1);
        rst = 1; in_valid = 0; out_ready = 1; step(); rst = 0;

        // mov r2,#5
        in_valid = 1; in_instr = 32'h4C800005; step(); in_valid = 0;
        chk("mov_fields", 32'({out_rs1_en, out_rs2_en, out_rd_we, out_rd, out_imm, out_op}),
            32'({1'b0, 1'b0, 1'b1, 4'd2, 1'b1, 5'd9}));

        // call then ret on RA
        in_valid = 1; in_instr = 32'h98000000; step();
        in_instr = 32'hA0000000; step();
        chk("ret_stall", 32'(last_stall), 1);
        step();
        chk("ret_stall_hold", 32'(last_stall), 1);
        wb_valid = 1; wb_reg = 4'd15; step(); wb_valid = 0;
`ifndef DEC_WB_BYPASS_EN
        chk("ret_wb_cycle_stall", 32'(last_stall), 1);
        step();
`endif
        chk("ret_release", 32'(last_stall), 0);
        chk("ret_rs1", 32'(out_rs1), 15);
        chk("ret_rs1_en", 32'(out_rs1_en), 1);
        in_valid = 0; step();

        // Counter saturation on r7, then writeback on an idle register
        rst = 1; step(); rst = 0;
        in_valid = 1; in_instr = 32'h01C00000;
        step(); step(); step(); step();
        chk("sat_stall", 32'(last_stall), 1);
        wb_valid = 1; wb_reg = 4'd7; step(); wb_valid = 0;
`ifndef DEC_WB_BYPASS_EN
        chk("sat_wb_cycle_stall", 32'(last_stall), 1);
        step();
`endif
        chk("sat_release", 32'(last_stall), 0);
        chk("sat_no_err", 32'(sb_err), 0);
        in_valid = 0; step();
        wb_valid = 1; wb_reg = 4'd9; step(); wb_valid = 0;
        chk("sb_err_set", 32'(sb_err), 1);
        step(); step();
        chk("sb_err_sticky", 32'(sb_err), 1);

        // Randomized traffic
        for (int n = 0; n < 800; n++) begin
            int op;
            int pq[$];
            rst = ($urandom_range(0, 99) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 9) == 0);
            op = ($urandom_range(0, 9) == 0) ? $urandom_range(21, 31) : $urandom_range(0, 20);
            in_instr = {5'(op), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)),
                        4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 14'($urandom)};
            for (int r = 0; r < 16; r++) if (mcnt[r] > 0) pq.push_back(r);
            wb_valid = ($urandom_range(0, 2) == 0);
            if (pq.size() > 0 && $urandom_range(0, 9) != 0)
                wb_reg = 4'(pq[$urandom_range(0, pq.size() - 1)]);
            else
                wb_reg = 4'($urandom_range(0, 15));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
